vga_timing_receiver: RTL and testbench

- Receiving end of the 640x480@60 VGA link driven by the display generator. Samples hsync, vsync and RGB565 on the pixel clock, measures line and frame timing, and locks to the expected timing.
- Once locked, emits pixel coordinates and pixel data for the active window.
- Used for loopback checking of the display path and as the front end of a frame-capture path.

---
 rtl/vga_timing_receiver_if.sv | 28 ++
 rtl/vga_timing_receiver.sv | 202 ++++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_receiver_if.sv
// VGA receive link: sampled sync/pixel inputs towards the receiver and the
// active-window pixel stream plus timing status coming back out of it.
interface vga_timing_receiver_if;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_start;
  logic        locked;
  logic [10:0] h_period;
  logic [10:0] v_lines;
  logic [7:0]  err_cnt;

  modport master (
    output hsync, vsync, rgb,
    input  pix_x, pix_y, pix_data, pix_valid, frame_start,
    input  locked, h_period, v_lines, err_cnt
  );

  modport slave (
    input  hsync, vsync, rgb,
    output pix_x, pix_y, pix_data, pix_valid, frame_start,
    output locked, h_period, v_lines, err_cnt
  );
endinterface

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: measures line/frame timing from hsync/vsync, locks to the
// expected raster and then emits active-window pixel coordinates and data.
module vga_timing_receiver #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned H_VALID     = 640,
  parameter int unsigned V_VALID     = 480,
  parameter bit          SYNC_POL    = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic                  vga_clk,
  input logic                  sys_rst,
  vga_timing_receiver_if.slave vif
);

  // state  | meaning
  // SEARCH | no timing reference; waiting for the first frame boundary
  // TRACK  | counting consecutive good frames towards lock
  // LOCKED | timing confirmed; active-window pixels are emitted
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [10:0] H_BEG   = 11'(H_ACT_START);
  localparam logic [10:0] H_END   = 11'(H_ACT_START + H_VALID);
  localparam logic [10:0] V_BEG   = 11'(V_ACT_START);
  localparam logic [10:0] V_END   = 11'(V_ACT_START + V_VALID);
  localparam logic [10:0] H_TMO   = 11'(2 * H_TOTAL);
  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [10:0] h_pos_q, h_pos_d;
  logic [10:0] v_pos_q, v_pos_d;
  logic        line_seen_q, line_seen_d;
  logic        vs_pend_q, vs_pend_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [10:0] h_period_q, h_period_d;
  logic [10:0] v_lines_q, v_lines_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        locked_q, locked_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;

  logic        hs_edge, vs_edge;
  logic        line_chk, line_err, boundary, timeout;
  logic        frame_good, lose_lock;
  logic [10:0] period;

  // h/v position tracking and line/frame measurement
  always_comb begin
    hs_prev_d = vif.hsync;
    vs_prev_d = vif.vsync;
    hs_edge   = (vif.hsync == SYNC_POL) && (hs_prev_q != SYNC_POL);
    vs_edge   = (vif.vsync == SYNC_POL) && (vs_prev_q != SYNC_POL);
    period    = h_pos_q + 11'd1;
    line_chk  = hs_edge && line_seen_q;
    line_err  = line_chk && (period != H_TOT);
    boundary  = hs_edge && (vs_pend_q || vs_edge);

    h_pos_d = (h_pos_q == CNT_MAX) ? CNT_MAX : h_pos_q + 11'd1;
    if (hs_edge) begin
      h_pos_d = '0;
    end
    timeout = !hs_edge && (h_pos_d == H_TMO);

    v_pos_d   = v_pos_q;
    vs_pend_d = vs_pend_q | vs_edge;
    v_lines_d = v_lines_q;
    if (boundary) begin
      v_pos_d   = '0;
      vs_pend_d = 1'b0;
      v_lines_d = v_pos_q + 11'd1;
    end else if (hs_edge && (v_pos_q != CNT_MAX)) begin
      v_pos_d = v_pos_q + 11'd1;
    end

    h_period_d = line_chk ? period : h_period_q;
  end

  // lock FSM and pixel output generation
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    err_cnt_d   = err_cnt_q;
    line_seen_d = line_seen_q | hs_edge;
    frame_err_d = boundary ? 1'b0 : (frame_err_q | line_err);
    frame_good  = (v_lines_d == V_TOT) && !frame_err_q && !line_err;
    lose_lock   = 1'b0;

    case (state_q)
      SEARCH: begin
        if (boundary) begin
          state_d    = TRACK;
          good_cnt_d = '0;
        end
      end
      TRACK: begin
        if (boundary) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_d == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        lose_lock = line_err || (boundary && !frame_good);
      end
      default: state_d = SEARCH;
    endcase

    // a fresh search must re-qualify the line period before trusting it
    if (timeout || lose_lock) begin
      state_d     = SEARCH;
      good_cnt_d  = '0;
      line_seen_d = 1'b0;
      frame_err_d = 1'b0;
    end
    if ((lose_lock || (timeout && (state_q == LOCKED))) && (err_cnt_q != 8'hff)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    locked_d = (state_d == LOCKED);

    pix_valid_d   = (state_q == LOCKED) &&
                    (h_pos_d >= H_BEG) && (h_pos_d < H_END) &&
                    (v_pos_d >= V_BEG) && (v_pos_d < V_END);
    pix_x_d       = pix_valid_d ? 10'(h_pos_d - H_BEG) : '0;
    pix_y_d       = pix_valid_d ? 10'(v_pos_d - V_BEG) : '0;
    pix_data_d    = pix_valid_d ? vif.rgb : '0;
    frame_start_d = pix_valid_d && (pix_x_d == '0) && (pix_y_d == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q       <= SEARCH;
      hs_prev_q     <= ~SYNC_POL;
      vs_prev_q     <= ~SYNC_POL;
      h_pos_q       <= '0;
      v_pos_q       <= '0;
      line_seen_q   <= 1'b0;
      vs_pend_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      good_cnt_q    <= '0;
      h_period_q    <= '0;
      v_lines_q     <= '0;
      err_cnt_q     <= '0;
      locked_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_pos_q       <= h_pos_d;
      v_pos_q       <= v_pos_d;
      line_seen_q   <= line_seen_d;
      vs_pend_q     <= vs_pend_d;
      frame_err_q   <= frame_err_d;
      good_cnt_q    <= good_cnt_d;
      h_period_q    <= h_period_d;
      v_lines_q     <= v_lines_d;
      err_cnt_q     <= err_cnt_d;
      locked_q      <= locked_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
    end
  end

  assign vif.pix_x       = pix_x_q;
  assign vif.pix_y       = pix_y_q;
  assign vif.pix_data    = pix_data_q;
  assign vif.pix_valid   = pix_valid_q;
  assign vif.frame_start = frame_start_q;
  assign vif.locked      = locked_q;
  assign vif.h_period    = h_period_q;
  assign vif.v_lines     = v_lines_q;
  assign vif.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver: directed raster stimulus, a per-cycle reference
// model of the receive rules, and hand-computed pins on lock timing and counts.
module tb_vga_timing_receiver;
  // reduced raster so that many frames fit in a short run
  localparam int HT = 40, VT = 20, HA = 9, VA = 3, HV = 24, VV = 14, LOCKN = 2;
  localparam int HSW = 6, VSW = 2;
  localparam int SEARCH_S = 0, TRACK_S = 1, LOCKED_S = 2;
  localparam logic [15:0] RED = 16'hF800, BLUE = 16'h001F, BORDER = 16'h5A5A;

  logic vga_clk = 1'b0;
  logic sys_rst = 1'b1;

  vga_timing_receiver_if vif ();

  vga_timing_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HA), .V_ACT_START(VA),
    .H_VALID(HV), .V_VALID(VV), .SYNC_POL(1'b1), .LOCK_FRAMES(LOCKN)
  ) dut (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .vif     (vif)
  );

  always #20 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // reference model state
  int m_anchor, m_state, m_good, m_err, m_hper, m_vlin, m_vpos;
  bit m_hs_prev, m_vs_prev, m_seen, m_pend, m_ferr;
  bit m_armed = 1'b0;
  int e_x, e_y, e_data;
  bit e_valid, e_fs, e_locked;

  always @(posedge vga_clk) begin : model
    int hpos, prev_h, st_now;
    bit hs_e, vs_e, bnd, lerr, tmo, good_frame, go_search;
    cyc++;
    if (sys_rst) begin
      m_anchor = cyc; m_state = SEARCH_S; m_good = 0; m_err = 0;
      m_hper = 0; m_vlin = 0; m_vpos = 0;
      m_hs_prev = 0; m_vs_prev = 0; m_seen = 0; m_pend = 0; m_ferr = 0;
      e_valid = 0; e_x = 0; e_y = 0; e_data = 0; e_fs = 0; e_locked = 0;
      m_armed = 1;
    end else begin
      hs_e = vif.hsync && !m_hs_prev;
      vs_e = vif.vsync && !m_vs_prev;
      m_hs_prev = vif.hsync;
      m_vs_prev = vif.vsync;
      prev_h = (cyc - 1 - m_anchor > 2047) ? 2047 : cyc - 1 - m_anchor;
      hpos = hs_e ? 0 : ((cyc - m_anchor > 2047) ? 2047 : cyc - m_anchor);
      st_now = m_state;
      bnd = 0;
      lerr = 0;
      tmo = !hs_e && (hpos == 2 * HT);
      if (hs_e) begin
        if (m_seen) begin
          m_hper = (prev_h + 1) % 2048;
          lerr = (m_hper != HT);
        end
        m_seen = 1;
        m_anchor = cyc;
        if (m_pend || vs_e) begin
          bnd = 1;
          m_vlin = (m_vpos + 1) % 2048;
          m_vpos = 0;
          m_pend = 0;
        end else if (m_vpos < 2047) begin
          m_vpos++;
        end
      end else if (vs_e) begin
        m_pend = 1;
      end
      good_frame = bnd && (m_vlin == VT) && !m_ferr && !lerr;
      go_search = tmo;
      if (st_now == SEARCH_S && bnd) begin
        m_state = TRACK_S;
        m_good = 0;
      end else if (st_now == TRACK_S && bnd) begin
        if (good_frame) begin
          m_good++;
          if (m_good == LOCKN) m_state = LOCKED_S;
        end else begin
          m_good = 0;
        end
      end else if (st_now == LOCKED_S && (lerr || (bnd && !good_frame))) begin
        go_search = 1;
      end
      if (go_search && st_now == LOCKED_S && m_err < 255) m_err++;
      m_ferr = bnd ? 0 : (m_ferr || lerr);
      if (go_search) begin
        m_state = SEARCH_S; m_good = 0; m_seen = 0; m_ferr = 0;
      end
      e_valid = (st_now == LOCKED_S) && hpos >= HA && hpos < HA + HV && m_vpos >= VA && m_vpos < VA + VV;
      e_x = e_valid ? hpos - HA : 0;
      e_y = e_valid ? m_vpos - VA : 0;
      e_data = e_valid ? int'(vif.rgb) : 0;
      e_fs = e_valid && e_x == 0 && e_y == 0;
      e_locked = (m_state == LOCKED_S);
    end
  end

  // per-cycle comparison plus tallies of what the DUT emitted
  int valid_cnt = 0;
  int fs_cnt = 0;
  int data_l = 0;
  int data_r = 0;

  always @(negedge vga_clk) begin
    if (m_armed) begin
      chk("locked", int'(vif.locked), int'(e_locked));
      chk("pix_valid", int'(vif.pix_valid), int'(e_valid));
      chk("pix_x", int'(vif.pix_x), e_x);
      chk("pix_y", int'(vif.pix_y), e_y);
      chk("pix_data", int'(vif.pix_data), e_data);
      chk("frame_start", int'(vif.frame_start), int'(e_fs));
      chk("h_period", int'(vif.h_period), m_hper);
      chk("v_lines", int'(vif.v_lines), m_vlin);
      chk("err_cnt", int'(vif.err_cnt), m_err);
      if (vif.pix_valid) valid_cnt++;
      if (vif.frame_start) fs_cnt++;
      if (vif.pix_valid && vif.pix_y == 10'd5 && vif.pix_x == 10'(HV / 2 - 1)) data_l = int'(vif.pix_data);
      if (vif.pix_valid && vif.pix_y == 10'd5 && vif.pix_x == 10'(HV / 2)) data_r = int'(vif.pix_data);
    end
  end

  function automatic logic [15:0] pix_color(input int h, input int ln);
    if (h >= HA && h < HA + HV && ln >= VA && ln < VA + VV)
      return (h - HA < HV / 2) ? RED : BLUE;
    return BORDER;
  endfunction

  task automatic drive(input bit hs, input bit vs, input logic [15:0] px);
    vif.hsync = hs;
    vif.vsync = vs;
    vif.rgb   = px;
    @(negedge vga_clk);
  endtask

  // lines first_ln..first_ln+count-1; short_ln is one clock short; pins checked after the first cycle
  task automatic gen_lines(input int first_ln, input int count, input int short_ln,
                           input int pin_lock, input int pin_err);
    int len;
    for (int ln = first_ln; ln < first_ln + count; ln++) begin
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        drive(h < HSW, ln < VSW, pix_color(h, ln));
        if (ln == first_ln && h == 0) begin
          if (pin_lock >= 0) chk("pin_locked", int'(vif.locked), pin_lock);
          if (pin_err >= 0) chk("pin_err_cnt", int'(vif.err_cnt), pin_err);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, int'(vif.locked), 0);
    chk({tag, "_pix_valid"}, int'(vif.pix_valid), 0);
    chk({tag, "_pix_xy"}, int'(vif.pix_x) + int'(vif.pix_y), 0);
    chk({tag, "_pix_data"}, int'(vif.pix_data), 0);
    chk({tag, "_frame_start"}, int'(vif.frame_start), 0);
    chk({tag, "_h_period"}, int'(vif.h_period), 0);
    chk({tag, "_v_lines"}, int'(vif.v_lines), 0);
    chk({tag, "_err_cnt"}, int'(vif.err_cnt), 0);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation exceeded time budget, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, f0;
    vif.hsync = 1'b0;
    vif.vsync = 1'b0;
    vif.rgb   = 16'h0000;
    drive(0, 0, BORDER);
    drive(0, 0, BORDER);
    sys_rst = 1'b0;
    check_all_zero("reset");

    // nominal acquisition: boundary 1 -> TRACK, lock right after boundary 3
    gen_lines(0, VT, -1, 0, 0);
    gen_lines(0, VT, -1, 0, 0);
    chk("locked_before_3rd_boundary", int'(vif.locked), 0);
    gen_lines(0, VT, -1, 1, 0);
    v0 = valid_cnt;
    f0 = fs_cnt;
    gen_lines(0, VT, -1, 1, 0);
    chk("valid_per_frame", valid_cnt - v0, HV * VV);
    chk("frame_start_per_frame", fs_cnt - f0, 1);
    chk("data_last_red", data_l, 16'hF800);
    chk("data_first_blue", data_r, 16'h001F);
    gen_lines(0, VT, -1, 1, 0);
    chk("h_period_nominal", int'(vif.h_period), 40);
    chk("v_lines_nominal", int'(vif.v_lines), 20);

    // short line while locked: lock drops right after the offending edge
    gen_lines(0, 8, 7, 1, 0);
    chk("locked_before_short_edge", int'(vif.locked), 1);
    gen_lines(8, VT - 8, -1, 0, 1);
    gen_lines(0, VT, -1, 0, 1);
    gen_lines(0, VT, -1, 0, 1);
    gen_lines(0, VT, -1, 1, 1);

    // hsync stuck inactive: timeout at h position 2*HT
    for (int i = 0; i < 100; i++) begin
      drive(i < HSW, 0, BORDER);
      if (i == 2 * HT - 1) chk("locked_before_timeout", int'(vif.locked), 1);
      if (i == 2 * HT) begin
        chk("locked_after_timeout", int'(vif.locked), 0);
        chk("err_after_timeout", int'(vif.err_cnt), 2);
        chk("valid_after_timeout", int'(vif.pix_valid), 0);
      end
    end

    // one 19-line frame while tracking delays lock by a frame
    gen_lines(0, VT - 1, -1, 0, 2);
    gen_lines(0, VT, -1, 0, 2);
    chk("v_lines_short_frame", int'(vif.v_lines), 19);
    gen_lines(0, VT, -1, 0, 2);
    gen_lines(0, VT, -1, 1, 2);

    // reset mid-frame while locked
    gen_lines(0, 10, -1, 1, 2);
    for (int h = 0; h < 15; h++) drive(h < HSW, 0, pix_color(h, 10));
    sys_rst = 1'b1;
    drive(0, 0, BORDER);
    sys_rst = 1'b0;
    check_all_zero("midreset");
    gen_lines(0, VT, -1, 0, 0);
    gen_lines(0, VT, -1, 0, 0);
    gen_lines(0, VT, -1, 1, 0);
    gen_lines(0, VT, -1, 1, 0);
    chk("h_period_relock", int'(vif.h_period), 40);
    chk("v_lines_relock", int'(vif.v_lines), 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
